// File: rtl/stack_cpu.sv
`default_nettype none
// ============================================================================
// Module      : stack_cpu
// Description : Stack-machine core. Fetches 1-word opcodes (plus an optional
//               1-word operand) from program ROM and keeps its operand stack
//               in data RAM. Traps on stack over/underflow and bad opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_cpu #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 256,
    parameter int MEM_LAT     = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic [3:0]        state,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_OPND   = 4'd2;
    localparam logic [3:0] c_ST_RD     = 4'd3;
    localparam logic [3:0] c_ST_WB     = 4'd4;
    localparam logic [3:0] c_ST_HALT   = 4'd5;
    localparam logic [3:0] c_ST_ERROR  = 4'd6;

    localparam logic [DATA_W-1:0] c_OP_NOP  = DATA_W'(16'h0000);
    localparam logic [DATA_W-1:0] c_OP_IMM  = DATA_W'(16'h0002);
    localparam logic [DATA_W-1:0] c_OP_JMP  = DATA_W'(16'h1000);
    localparam logic [DATA_W-1:0] c_OP_JZ   = DATA_W'(16'h1001);
    localparam logic [DATA_W-1:0] c_OP_ADD  = DATA_W'(16'h2000);
    localparam logic [DATA_W-1:0] c_OP_SUB  = DATA_W'(16'h2001);
    localparam logic [DATA_W-1:0] c_OP_AND  = DATA_W'(16'h2002);
    localparam logic [DATA_W-1:0] c_OP_OR   = DATA_W'(16'h2003);
    localparam logic [DATA_W-1:0] c_OP_DUP  = DATA_W'(16'h3000);
    localparam logic [DATA_W-1:0] c_OP_DROP = DATA_W'(16'h3001);
    localparam logic [DATA_W-1:0] c_OP_HALT = DATA_W'(16'hFFFF);

    // Latched instruction kind; bit 2 set marks the binary ALU ops, whose
    // low bits mirror the opcode's low bits.
    localparam logic [2:0] c_K_IMM = 3'd0;
    localparam logic [2:0] c_K_JMP = 3'd1;
    localparam logic [2:0] c_K_JZ  = 3'd2;
    localparam logic [2:0] c_K_DUP = 3'd3;
    localparam logic [2:0] c_K_ADD = 3'd4;
    localparam logic [2:0] c_K_SUB = 3'd5;
    localparam logic [2:0] c_K_AND = 3'd6;
    localparam logic [2:0] c_K_OR  = 3'd7;

    localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] c_ERR_OVER    = 2'd2;
    localparam logic [1:0] c_ERR_UNDER   = 2'd3;

    localparam int                 c_CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MEM_LAT);
    localparam logic [ADDR_W-1:0]  c_DEPTH    = ADDR_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0]  c_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  c_TWO      = ADDR_W'(2);

    logic [3:0]         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_sp, w_sp_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic [DATA_W-1:0]  r_a, w_a_nxt;
    logic [1:0]         r_err, w_err_nxt;
    logic [DATA_W-1:0]  w_alu;
    logic               w_is_bin;

    assign w_is_bin = r_op[2];
    assign pc       = r_pc;
    assign sp       = r_sp;
    assign state    = r_state;
    assign halted   = (r_state == c_ST_HALT);
    assign error    = (r_state == c_ST_ERROR);
    assign err_code = r_err;

    // State and datapath registers; reset may land mid-instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_FETCH;
            r_pc    <= '0;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_op    <= c_K_IMM;
            r_a     <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ALU: b arrives on ram_q during WB, a was captured one cycle earlier.
    always_comb begin
        w_alu = '0;
        case (r_op)
            c_K_ADD: w_alu = ram_q + r_a;
            c_K_SUB: w_alu = ram_q - r_a;
            c_K_AND: w_alu = ram_q & r_a;
            c_K_OR:  w_alu = ram_q | r_a;
            default: w_alu = '0;
        endcase
    end

    // Next-state, memory addressing and write strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_err_nxt   = r_err;
        rom_addr    = r_pc;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_wren    = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DECODE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_DECODE: begin
                w_cnt_nxt = '0;
                case (rom_q)
                    c_OP_NOP: begin
                        w_pc_nxt    = r_pc + c_ONE;
                        w_state_nxt = c_ST_FETCH;
                    end
                    c_OP_IMM: begin
                        if (r_sp == c_DEPTH) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_OVER;
                        end else begin
                            w_op_nxt    = c_K_IMM;
                            w_state_nxt = c_ST_OPND;
                        end
                    end
                    c_OP_JMP: begin
                        w_op_nxt    = c_K_JMP;
                        w_state_nxt = c_ST_OPND;
                    end
                    c_OP_JZ: begin
                        if (r_sp == '0) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_UNDER;
                        end else begin
                            w_op_nxt    = c_K_JZ;
                            w_state_nxt = c_ST_OPND;
                        end
                    end
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                        if (r_sp < c_TWO) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_UNDER;
                        end else begin
                            w_op_nxt    = {1'b1, rom_q[1:0]};
                            w_state_nxt = c_ST_RD;
                        end
                    end
                    c_OP_DUP: begin
                        if (r_sp == '0) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_UNDER;
                        end else if (r_sp == c_DEPTH) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_OVER;
                        end else begin
                            w_op_nxt    = c_K_DUP;
                            w_state_nxt = c_ST_RD;
                        end
                    end
                    c_OP_DROP: begin
                        if (r_sp == '0) begin
                            w_state_nxt = c_ST_ERROR;
                            w_err_nxt   = c_ERR_UNDER;
                        end else begin
                            w_sp_nxt    = r_sp - c_ONE;
                            w_pc_nxt    = r_pc + c_ONE;
                            w_state_nxt = c_ST_FETCH;
                        end
                    end
                    c_OP_HALT: w_state_nxt = c_ST_HALT;
                    default: begin
                        w_state_nxt = c_ST_ERROR;
                        w_err_nxt   = c_ERR_ILLEGAL;
                    end
                endcase
            end
            c_ST_OPND: begin
                // JZ reads its condition alongside the ROM operand.
                rom_addr = r_pc + c_ONE;
                if (r_op == c_K_JZ) begin
                    ram_addr = r_sp - c_ONE;
                end
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_WB;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_RD: begin
                // Binary ops issue a then b on consecutive cycles; a lands
                // MEM_LAT cycles after issue and is held for the ALU.
                ram_addr = (w_is_bin && r_cnt != '0) ? (r_sp - c_TWO) : (r_sp - c_ONE);
                if (w_is_bin && r_cnt == c_CNT_FULL) begin
                    w_a_nxt = ram_q;
                end
                if (r_cnt == (w_is_bin ? c_CNT_FULL : c_CNT_LAST)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_WB;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_WB: begin
                rom_addr    = r_pc + c_ONE;
                w_state_nxt = c_ST_FETCH;
                case (r_op)
                    c_K_IMM: begin
                        ram_wren  = 1'b1;
                        ram_addr  = r_sp;
                        ram_wdata = rom_q;
                        w_sp_nxt  = r_sp + c_ONE;
                        w_pc_nxt  = r_pc + c_TWO;
                    end
                    c_K_JMP: w_pc_nxt = ADDR_W'(rom_q);
                    c_K_JZ: begin
                        w_pc_nxt = (ram_q == '0) ? ADDR_W'(rom_q) : (r_pc + c_TWO);
                        w_sp_nxt = r_sp - c_ONE;
                    end
                    c_K_DUP: begin
                        ram_wren  = 1'b1;
                        ram_addr  = r_sp;
                        ram_wdata = ram_q;
                        w_sp_nxt  = r_sp + c_ONE;
                        w_pc_nxt  = r_pc + c_ONE;
                    end
                    default: begin
                        ram_wren  = 1'b1;
                        ram_addr  = r_sp - c_TWO;
                        ram_wdata = w_alu;
                        w_sp_nxt  = r_sp - c_ONE;
                        w_pc_nxt  = r_pc + c_ONE;
                    end
                endcase
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_cpu
// Description : Self-checking bench for stack_cpu. Four cores with different
//               depth/latency share one clock; one is active at a time while
//               the others sit in reset. RAM writes are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_cpu;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [4];
    logic        clr       [4];
    logic [15:0] rom_addr  [4];
    logic [15:0] rom_q     [4];
    logic [15:0] ram_addr  [4];
    logic [15:0] ram_wdata [4];
    logic [15:0] ram_q     [4];
    logic [15:0] pc        [4];
    logic [15:0] sp        [4];
    logic        ram_wren  [4];
    logic        halted    [4];
    logic        error     [4];
    logic [3:0]  state     [4];
    logic [1:0]  err_code  [4];
    logic [15:0] rom       [4][65536];
    logic [15:0] ram       [4][65536];
    logic [15:0] rom_pipe  [4][4];
    logic [15:0] ram_pipe  [4][4];

    wr_t exp_q[$];
    int  pc_edges[$];
    int  compared   = 0;
    int  mismatched = 0;

    function automatic int lat_of(input int k);
        return (k == 2) ? 1 : ((k == 3) ? 3 : 2);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 1) ? 2 : 256;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        stack_cpu #(
            .DATA_W(16), .ADDR_W(16),
            .STACK_DEPTH(depth_of(gi)), .MEM_LAT(lat_of(gi))
        ) u_dut (
            .clock(clk), .reset_n(rst_n[gi]),
            .rom_addr(rom_addr[gi]), .rom_q(rom_q[gi]),
            .ram_addr(ram_addr[gi]), .ram_wdata(ram_wdata[gi]),
            .ram_wren(ram_wren[gi]), .ram_q(ram_q[gi]),
            .pc(pc[gi]), .sp(sp[gi]), .state(state[gi]),
            .halted(halted[gi]), .error(error[gi]), .err_code(err_code[gi])
        );
        assign rom_q[gi] = rom_pipe[gi][lat_of(gi)-1];
        assign ram_q[gi] = ram_pipe[gi][lat_of(gi)-1];
    end

    // Pipelined ROM/RAM models: address sampled at an edge, data MEM_LAT cycles later.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            rom_pipe[k][0] <= rom[k][rom_addr[k]];
            ram_pipe[k][0] <= ram[k][ram_addr[k]];
            for (int j = 1; j < 4; j++) begin
                rom_pipe[k][j] <= rom_pipe[k][j-1];
                ram_pipe[k][j] <= ram_pipe[k][j-1];
            end
            if (clr[k]) begin
                for (int i = 0; i < 65536; i++) ram[k][i] <= 16'hDEAD;
            end else if (ram_wren[k]) begin
                ram[k][ram_addr[k]] <= ram_wdata[k];
            end
        end
    end

    task automatic prep(input int k);
        for (int i = 0; i < 65536; i++) rom[k][i] = 16'hFFFF;
        clr[k] = 1'b1;
        @(posedge clk); #1;
        clr[k] = 1'b0;
        exp_q.delete();
        pc_edges.delete();
    endtask

    task automatic go(input int k);
        @(negedge clk); rst_n[k] = 1'b1;
    endtask

    task automatic stop(input int k);
        @(negedge clk); rst_n[k] = 1'b0;
    endtask

    task automatic push_w(input logic [15:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    // Step the active core, scoreboarding writes, until halted/error, a
    // write at stop_pc (when stop_wb) or the cycle budget runs out.
    task automatic run(input int k, input int budget, input bit stop_wb,
                       input logic [15:0] stop_pc, output int edges);
        logic [15:0] last_pc;
        wr_t w;
        bit done;
        edges = 0; done = 1'b0; last_pc = pc[k];
        while (!done && edges < budget) begin
            @(posedge clk); #1;
            edges++;
            if (stop_wb && ram_wren[k] && pc[k] == stop_pc) begin
                done = 1'b1;
            end else if (ram_wren[k]) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", ram_addr[k], ram_wdata[k]);
                end else begin
                    w = exp_q.pop_front();
                    if (ram_addr[k] !== w.addr || ram_wdata[k] !== w.data) begin
                        mismatched++;
                        $display("FAIL ram_write: got %h<=%h, expected %h<=%h", ram_addr[k], ram_wdata[k], w.addr, w.data);
                    end
                end
            end
            if (pc[k] !== last_pc) begin
                pc_edges.push_back(edges);
                last_pc = pc[k];
            end
            if (halted[k] || error[k]) done = 1'b1;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL timeout: core %0d ran %0d cycles, expected stop", k, edges);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [88:0] v;
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            v = {pc[k], sp[k], state[k], halted[k], error[k], err_code[k],
                 ram_wren[k], ram_addr[k], ram_wdata[k], rom_addr[k]};
            compared++;
            if (v !== '0) begin
                mismatched++;
                $display("FAIL reset_state core%0d: got %h, expected 0", k, v);
            end
        end
    endtask

    // IMM 3, IMM 5, SUB, HALT with per-instruction cycle counts.
    task automatic test_basic(input int k);
        int edges, l;
        l = lat_of(k);
        prep(k);
        rom[k][0] = 16'h0002; rom[k][1] = 16'd3;
        rom[k][2] = 16'h0002; rom[k][3] = 16'd5;
        rom[k][4] = 16'h2001; rom[k][5] = 16'hFFFF;
        push_w(16'd0, 16'd3); push_w(16'd1, 16'd5); push_w(16'd0, 16'd3 - 16'd5);
        go(k);
        run(k, 300, 1'b0, 16'h0, edges);
        compared++;
        if (halted[k] !== 1'b1 || pc[k] !== 16'd5 || sp[k] !== 16'd1) begin
            mismatched++;
            $display("FAIL basic_final L%0d: got h%b pc %h sp %h, expected h1 pc 0005 sp 0001", l, halted[k], pc[k], sp[k]);
        end
        compared++;
        if (ram[k][0] !== 16'hFFFE) begin
            mismatched++;
            $display("FAIL basic_ram0 L%0d: got %h, expected fffe", l, ram[k][0]);
        end
        compared++;
        if (edges != 7 * l + 8) begin
            mismatched++;
            $display("FAIL basic_cycles L%0d: got %0d, expected %0d", l, edges, 7 * l + 8);
        end
        compared++;
        if (pc_edges.size() < 3 || pc_edges[0] != 2*l+2 || pc_edges[1] != 4*l+4 || pc_edges[2] != 6*l+7) begin
            mismatched++;
            $display("FAIL basic_instr_edges L%0d: got n=%0d %0d %0d %0d, expected %0d %0d %0d",
                     l, pc_edges.size(), pc_edges[0], pc_edges[1], pc_edges[2], 2*l+2, 4*l+4, 6*l+7);
        end
        stop(k);
    endtask

    task automatic test_jz();
        int edges;
        for (int pass = 0; pass < 2; pass++) begin
            prep(0);
            rom[0][0] = 16'h0002; rom[0][1] = (pass == 0) ? 16'd0 : 16'd1;
            rom[0][2] = 16'h1001; rom[0][3] = 16'h0010;
            rom[0][16] = 16'h0002; rom[0][17] = 16'd7; rom[0][18] = 16'hFFFF;
            push_w(16'd0, (pass == 0) ? 16'd0 : 16'd1);
            if (pass == 0) push_w(16'd0, 16'd7);
            go(0);
            run(0, 300, 1'b0, 16'h0, edges);
            compared++;
            if (pass == 0 && (pc[0] !== 16'h0012 || sp[0] !== 16'd1 || halted[0] !== 1'b1 || ram[0][0] !== 16'd7)) begin
                mismatched++;
                $display("FAIL jz_taken: got pc %h sp %h h%b ram0 %h, expected 0012 0001 h1 0007", pc[0], sp[0], halted[0], ram[0][0]);
            end else if (pass == 1 && (pc[0] !== 16'h0004 || sp[0] !== 16'd0 || halted[0] !== 1'b1)) begin
                mismatched++;
                $display("FAIL jz_fallthrough: got pc %h sp %h h%b, expected 0004 0000 h1", pc[0], sp[0], halted[0]);
            end
            stop(0);
        end
    endtask

    task automatic test_overflow();
        int edges;
        prep(1);
        rom[1][0] = 16'h0002; rom[1][1] = 16'd1;
        rom[1][2] = 16'h0002; rom[1][3] = 16'd2;
        rom[1][4] = 16'h0002; rom[1][5] = 16'd3;
        push_w(16'd0, 16'd1); push_w(16'd1, 16'd2);
        go(1);
        run(1, 300, 1'b0, 16'h0, edges);
        compared++;
        if (error[1] !== 1'b1 || err_code[1] !== 2'd2 || sp[1] !== 16'd2 || pc[1] !== 16'd4) begin
            mismatched++;
            $display("FAIL overflow: got e%b code %0d sp %h pc %h, expected e1 code 2 sp 0002 pc 0004", error[1], err_code[1], sp[1], pc[1]);
        end
        compared++;
        if (ram[1][2] !== 16'hDEAD) begin
            mismatched++;
            $display("FAIL overflow_ram2: got %h, expected dead", ram[1][2]);
        end
        stop(1);
    endtask

    task automatic test_underflow_illegal();
        int edges;
        prep(0);
        rom[0][0] = 16'h0002; rom[0][1] = 16'd9; rom[0][2] = 16'h2000;
        push_w(16'd0, 16'd9);
        go(0);
        run(0, 300, 1'b0, 16'h0, edges);
        compared++;
        if (error[0] !== 1'b1 || err_code[0] !== 2'd3 || sp[0] !== 16'd1 || pc[0] !== 16'd2 || halted[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL underflow: got e%b code %0d sp %h pc %h, expected e1 code 3 sp 0001 pc 0002", error[0], err_code[0], sp[0], pc[0]);
        end
        stop(0);
        prep(0);
        rom[0][0] = 16'h1234;
        go(0);
        run(0, 300, 1'b0, 16'h0, edges);
        compared++;
        if (error[0] !== 1'b1 || err_code[0] !== 2'd1 || pc[0] !== 16'd0 || sp[0] !== 16'd0 || edges != 3) begin
            mismatched++;
            $display("FAIL illegal: got e%b code %0d pc %h sp %h cyc %0d, expected e1 code 1 pc 0 sp 0 cyc 3", error[0], err_code[0], pc[0], sp[0], edges);
        end
        stop(0);
    endtask

    task automatic test_logic();
        int edges;
        prep(0);
        rom[0][0] = 16'h0002; rom[0][1] = 16'hF0F0; rom[0][2] = 16'h3000;
        rom[0][3] = 16'h2002; rom[0][4] = 16'h0002; rom[0][5] = 16'h0F0F;
        rom[0][6] = 16'h2003; rom[0][7] = 16'hFFFF;
        push_w(16'd0, 16'hF0F0); push_w(16'd1, 16'hF0F0);
        push_w(16'd0, 16'hF0F0 & 16'hF0F0); push_w(16'd1, 16'h0F0F);
        push_w(16'd0, 16'hF0F0 | 16'h0F0F);
        go(0);
        run(0, 400, 1'b0, 16'h0, edges);
        compared++;
        if (ram[0][0] !== 16'hFFFF || sp[0] !== 16'd1 || pc[0] !== 16'd7 || halted[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL logic: got ram0 %h sp %h pc %h h%b, expected ffff 0001 0007 h1", ram[0][0], sp[0], pc[0], halted[0]);
        end
        stop(0);
    endtask

    task automatic test_reset_mid_wb();
        int edges;
        logic [88:0] v;
        prep(0);
        rom[0][0] = 16'h0002; rom[0][1] = 16'd4; rom[0][2] = 16'h0002;
        rom[0][3] = 16'd6;    rom[0][4] = 16'h2000; rom[0][5] = 16'hFFFF;
        push_w(16'd0, 16'd4); push_w(16'd1, 16'd6);
        go(0);
        run(0, 300, 1'b1, 16'd4, edges);
        compared++;
        if (state[0] !== 4'd4 || ram_wren[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL midwb_reach: got state %0d wren %b, expected 4 1", state[0], ram_wren[0]);
        end
        #1 rst_n[0] = 1'b0;
        #1;
        v = {pc[0], sp[0], state[0], halted[0], error[0], err_code[0],
             ram_wren[0], ram_addr[0], ram_wdata[0], rom_addr[0]};
        compared++;
        if (v !== '0) begin
            mismatched++;
            $display("FAIL midwb_async_reset: got %h, expected 0", v);
        end
        repeat (2) @(posedge clk); #1;
        compared++;
        if (ram[0][0] !== 16'd4) begin
            mismatched++;
            $display("FAIL midwb_no_write: got ram0 %h, expected 0004", ram[0][0]);
        end
        push_w(16'd0, 16'd4); push_w(16'd1, 16'd6); push_w(16'd0, 16'd10);
        go(0);
        run(0, 300, 1'b0, 16'h0, edges);
        compared++;
        if (pc[0] !== 16'd5 || sp[0] !== 16'd1 || halted[0] !== 1'b1 || ram[0][0] !== 16'd10) begin
            mismatched++;
            $display("FAIL midwb_restart: got pc %h sp %h h%b ram0 %h, expected 0005 0001 h1 000a", pc[0], sp[0], halted[0], ram[0][0]);
        end
        stop(0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0;
            clr[k]   = 1'b0;
        end
        test_reset();
        test_basic(0);
        test_basic(2);
        test_basic(3);
        test_jz();
        test_overflow();
        test_underflow_illegal();
        test_logic();
        test_reset_mid_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
